mpu_matrix_loader: RTL

//  Upstream feeder for the MPU determinant stage. Accepts a size code and a byte stream of

---
 rtl/mpu_pkg.sv | 17 +
 rtl/mpu_elem_index.sv | 43 ++++
 rtl/mpu_matrix_loader.sv | 104 ++++++++++
 3 files changed

// File: rtl/mpu_pkg.sv
// Shared constants, state encoding and element-offset helper for the MPU loader.
package mpu_pkg;
  localparam int DIM_MAX     = 5;
  localparam int INT8_W      = 8;
  localparam int MATRIX_BITS = DIM_MAX * DIM_MAX * INT8_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Bit offset of element (r,c) in the row-major matrix bus.
  function automatic int at(input int r, input int c);
    return INT8_W * (c + DIM_MAX * r);
  endfunction
endpackage

// File: rtl/mpu_elem_index.sv
// Tracks the (row,col) slot of the next streamed element and flags the final one.
// Column-major walk when MPU_LOADER_TRANSPOSE_EN is defined, row-major otherwise.
module mpu_elem_index (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       advance,
  input  logic [2:0] dim,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);
  logic [2:0] lim;

  assign lim  = dim - 3'd1;
  assign last = (row == lim) && (col == lim);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row <= 3'd0;
      col <= 3'd0;
    end else if (clear || (advance && last)) begin
      row <= 3'd0;
      col <= 3'd0;
    end else if (advance) begin
`ifdef MPU_LOADER_TRANSPOSE_EN
      if (row == lim) begin
        row <= 3'd0;
        col <= col + 3'd1;
      end else begin
        row <= row + 3'd1;
      end
`else
      if (col == lim) begin
        col <= 3'd0;
        row <= row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
`endif
    end
  end
endmodule

// File: rtl/mpu_matrix_loader.sv
// Packs a signed int8 stream into the 5x5 det bus, holds it SETTLE_CYCLES, then pulses det_strobe.
// data_ready depends only on state (high in LOAD); MPU_LOADER_TRANSPOSE_EN selects column-major order.
module mpu_matrix_loader
  import mpu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 12
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic signed [7:0]       size_in,
  input  logic [7:0]              data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [0:MATRIX_BITS-1]  matrix,
  output logic signed [7:0]       size,
  output logic                    busy,
  output logic                    det_strobe,
  output logic                    size_err
);
  localparam logic signed [7:0] DIM_S = 8'(DIM_MAX);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] settle_cnt;
  logic [2:0] row;
  logic [2:0] col;
  logic       last;
  logic       size_ok;
  logic       load_go;
  logic       hs;
  logic       settle_done;

  assign size_ok     = (size_in > 8'sd0) && (size_in <= DIM_S);
  assign load_go     = (state == IDLE) && start && size_ok;
  assign data_ready  = (state == LOAD);
  assign busy        = (state != IDLE);
  assign hs          = data_valid && data_ready;
  assign settle_done = (settle_cnt == 8'(SETTLE_CYCLES - 1));

  mpu_elem_index u_index (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (load_go),
    .advance (hs),
    .dim     (size[2:0]),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  always_comb begin
    state_nxt  = state;
    det_strobe = 1'b0;
    case (state)
      IDLE:   if (load_go) state_nxt = LOAD;
      LOAD:   if (hs && last) state_nxt = SETTLE;
      SETTLE: begin
        if (settle_done) begin
          det_strobe = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                settle_cnt <= 8'd0;
    else if ((state == SETTLE) && !settle_done)  settle_cnt <= settle_cnt + 8'd1;
    else                                         settle_cnt <= 8'd0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      size     <= 8'sd0;
      size_err <= 1'b0;
    end else begin
      size_err <= (state == IDLE) && start && !size_ok;
      if (load_go) size <= size_in;
    end
  end

  // Write decoder: one enable per slot keeps the byte lanes at constant offsets.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      matrix <= '0;
    end else if (load_go) begin
      matrix <= '0;
    end else begin
      for (int r = 0; r < DIM_MAX; r++) begin
        for (int c = 0; c < DIM_MAX; c++) begin
          if (hs && (row == 3'(r)) && (col == 3'(c)))
            matrix[at(r, c) +: INT8_W] <= data_in;
        end
      end
    end
  end
endmodule
